// File: rtl/pipe_pkg.sv
// Shared MIPS pipeline constants: control-bundle bit positions, instruction
// register-field positions and the all-zero bubble control word.
package pipe_pkg;

    // Control bundle layout, LSB first
    localparam int ALUSRC     = 0;
    localparam int REGDST     = 1;
    localparam int MEMWRITE   = 2;
    localparam int MEMREAD    = 3;
    localparam int MEMTOREG   = 4;
    localparam int REGWRITE   = 5;
    localparam int ALUOP_LSB  = 6;
    localparam int ALUOP_MSB  = 7;
    localparam int BRANCH_LSB = 8;
    localparam int BRANCH_MSB = 9;

    localparam int REG_ADDR_W = 5;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;

    // Wide enough for any bundle width; users slice the low CTRL_W bits
    localparam int CTRL_MAX_W = 64;
    localparam logic [CTRL_MAX_W-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector between the EX load and the ID
// instruction; kept standalone so the forwarding unit can share it.
module load_use_detect
    import pipe_pkg::*;
(
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  id_valid,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  flush,
    output logic                  load_use,
    output logic                  hazard_stall
);

    logic rs_match;
    logic rt_match;

    // $0 is hardwired to zero, so a load targeting it never creates a dependency
    always_comb begin
        rs_match     = (ex_rt == id_rs);
        rt_match     = id_uses_rt & (ex_rt == id_rt);
        load_use     = ex_valid & ex_mem_read & id_valid & (ex_rt != '0) & (rs_match | rt_match);
        hazard_stall = load_use & ~flush;
    end

endmodule

// File: rtl/id_exe_hazard_reg.sv
// ID/EX pipeline register with valid bit, hold, flush, built-in load-use
// bubble injection and a saturating bubble counter for performance debug.
module id_exe_hazard_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int CTRL_W      = 10,
    parameter int MEMREAD_IDX = MEMREAD,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_in,
    input  logic              flush_in,
    input  logic              id_valid_in,
    input  logic              id_uses_rt_in,
    input  logic [CTRL_W-1:0] id_ctrl_in,
    input  logic [DATA_W-1:0] id_read_data1_in,
    input  logic [DATA_W-1:0] id_read_data2_in,
    input  logic [DATA_W-1:0] id_imm_in,
    input  logic [DATA_W-1:0] id_instruction_in,
    input  logic [DATA_W-1:0] id_pc_in,
    output logic              ex_valid_out,
    output logic [CTRL_W-1:0] ex_ctrl_out,
    output logic [DATA_W-1:0] ex_read_data1_out,
    output logic [DATA_W-1:0] ex_read_data2_out,
    output logic [DATA_W-1:0] ex_imm_out,
    output logic [DATA_W-1:0] ex_instruction_out,
    output logic [DATA_W-1:0] ex_pc_out,
    output logic              hazard_stall_out,
    output logic [CNT_W-1:0]  bubble_count_out
);

    logic load_use;

    load_use_detect u_detect (
        .ex_valid     (ex_valid_out),
        .ex_mem_read  (ex_ctrl_out[MEMREAD_IDX]),
        .ex_rt        (ex_instruction_out[RT_MSB:RT_LSB]),
        .id_valid     (id_valid_in),
        .id_uses_rt   (id_uses_rt_in),
        .id_rs        (id_instruction_in[RS_MSB:RS_LSB]),
        .id_rt        (id_instruction_in[RT_MSB:RT_LSB]),
        .flush        (flush_in),
        .load_use     (load_use),
        .hazard_stall (hazard_stall_out)
    );

    // Priority: flush, then stall (hold), then load-use bubble, then normal load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_out       <= 1'b0;
            ex_ctrl_out        <= CTRL_BUBBLE[CTRL_W-1:0];
            ex_read_data1_out  <= '0;
            ex_read_data2_out  <= '0;
            ex_imm_out         <= '0;
            ex_instruction_out <= '0;
            ex_pc_out          <= '0;
        end else if (flush_in || (!stall_in && load_use)) begin
            ex_valid_out       <= 1'b0;
            ex_ctrl_out        <= CTRL_BUBBLE[CTRL_W-1:0];
            ex_read_data1_out  <= '0;
            ex_read_data2_out  <= '0;
            ex_imm_out         <= '0;
            ex_instruction_out <= '0;
            ex_pc_out          <= '0;
        end else if (!stall_in) begin
            ex_valid_out       <= id_valid_in;
            ex_ctrl_out        <= id_valid_in ? id_ctrl_in : CTRL_BUBBLE[CTRL_W-1:0];
            ex_read_data1_out  <= id_read_data1_in;
            ex_read_data2_out  <= id_read_data2_in;
            ex_imm_out         <= id_imm_in;
            ex_instruction_out <= id_instruction_in;
            ex_pc_out          <= id_pc_in;
        end
    end

    // Counts only bubbles actually injected by load-use; sticks at all-ones
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_count_out <= '0;
        end else if (load_use && !stall_in && !flush_in && (bubble_count_out != '1)) begin
            bubble_count_out <= bubble_count_out + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_exe_hazard_reg.sv
// Self-checking bench for id_exe_hazard_reg: directed scenarios followed by
// random traffic, all compared against a behavioural pipeline-stage model.
module tb_id_exe_hazard_reg;

    logic        clk;
    logic        reset;
    logic        stall_in;
    logic        flush_in;
    logic        id_valid_in;
    logic        id_uses_rt_in;
    logic [9:0]  id_ctrl_in;
    logic [31:0] id_read_data1_in;
    logic [31:0] id_read_data2_in;
    logic [31:0] id_imm_in;
    logic [31:0] id_instruction_in;
    logic [31:0] id_pc_in;

    logic        ex_valid_out, s_valid;
    logic [9:0]  ex_ctrl_out, s_ctrl;
    logic [31:0] ex_read_data1_out, ex_read_data2_out, ex_imm_out;
    logic [31:0] ex_instruction_out, ex_pc_out;
    logic [31:0] s_d1, s_d2, s_imm, s_ins, s_pc;
    logic        hazard_stall_out, s_hazard;
    logic [15:0] bubble_count_out;
    logic [1:0]  s_count;

    int total = 0;
    int bad   = 0;

    // Reference model: the instruction currently sitting in EX plus bubble tally
    logic        m_valid;
    logic [9:0]  m_ctrl;
    logic [31:0] m_d1, m_d2, m_imm, m_ins, m_pc;
    int          m_bubbles;

    id_exe_hazard_reg dut (
        .clk(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
        .id_valid_in(id_valid_in), .id_uses_rt_in(id_uses_rt_in), .id_ctrl_in(id_ctrl_in),
        .id_read_data1_in(id_read_data1_in), .id_read_data2_in(id_read_data2_in),
        .id_imm_in(id_imm_in), .id_instruction_in(id_instruction_in), .id_pc_in(id_pc_in),
        .ex_valid_out(ex_valid_out), .ex_ctrl_out(ex_ctrl_out),
        .ex_read_data1_out(ex_read_data1_out), .ex_read_data2_out(ex_read_data2_out),
        .ex_imm_out(ex_imm_out), .ex_instruction_out(ex_instruction_out), .ex_pc_out(ex_pc_out),
        .hazard_stall_out(hazard_stall_out), .bubble_count_out(bubble_count_out)
    );

    id_exe_hazard_reg #(.CNT_W(2)) dut_small (
        .clk(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
        .id_valid_in(id_valid_in), .id_uses_rt_in(id_uses_rt_in), .id_ctrl_in(id_ctrl_in),
        .id_read_data1_in(id_read_data1_in), .id_read_data2_in(id_read_data2_in),
        .id_imm_in(id_imm_in), .id_instruction_in(id_instruction_in), .id_pc_in(id_pc_in),
        .ex_valid_out(s_valid), .ex_ctrl_out(s_ctrl),
        .ex_read_data1_out(s_d1), .ex_read_data2_out(s_d2),
        .ex_imm_out(s_imm), .ex_instruction_out(s_ins), .ex_pc_out(s_pc),
        .hazard_stall_out(s_hazard), .bubble_count_out(s_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit modelLoadUse();
        int ex_rt, rs, rt;
        ex_rt = int'(m_ins[20:16]);
        rs    = int'(id_instruction_in[25:21]);
        rt    = int'(id_instruction_in[20:16]);
        return m_valid && m_ctrl[3] && id_valid_in && (ex_rt != 0) &&
               ((ex_rt == rs) || (id_uses_rt_in && ex_rt == rt));
    endfunction

    function automatic int sat(int n, int max);
        return (n > max) ? max : n;
    endfunction

    task automatic modelClear();
        m_valid = 0; m_ctrl = '0; m_d1 = '0; m_d2 = '0;
        m_imm = '0; m_ins = '0; m_pc = '0; m_bubbles = 0;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkOutput(string tag);
        chk({tag, ":valid"},  32'(ex_valid_out), 32'(m_valid));
        chk({tag, ":ctrl"},   32'(ex_ctrl_out), 32'(m_ctrl));
        chk({tag, ":d1"},     ex_read_data1_out, m_d1);
        chk({tag, ":d2"},     ex_read_data2_out, m_d2);
        chk({tag, ":imm"},    ex_imm_out, m_imm);
        chk({tag, ":ins"},    ex_instruction_out, m_ins);
        chk({tag, ":pc"},     ex_pc_out, m_pc);
        chk({tag, ":hazard"}, 32'(hazard_stall_out), 32'(modelLoadUse() && !flush_in));
        chk({tag, ":count"},  32'(bubble_count_out), 32'(sat(m_bubbles, 65535)));
        chk({tag, ":count2"}, 32'(s_count), 32'(sat(m_bubbles, 3)));
        chk({tag, ":s_valid"}, 32'(s_valid), 32'(m_valid));
    endtask

    task automatic applyStimulus(bit valid, bit uses_rt, logic [9:0] ctrl, logic [31:0] ins,
                                 logic [31:0] pc, bit stall, bit flush);
        id_valid_in = valid; id_uses_rt_in = uses_rt; id_ctrl_in = ctrl;
        id_instruction_in = ins; id_pc_in = pc; stall_in = stall; flush_in = flush;
        id_read_data1_in = $urandom; id_read_data2_in = $urandom; id_imm_in = $urandom;
    endtask

    // Advance one edge, updating the model from the inputs seen before the edge
    task automatic stepClock(string tag);
        bit lu;
        lu = modelLoadUse();
        @(posedge clk);
        if (flush_in || (!stall_in && lu)) begin
            if (!flush_in) m_bubbles++;
            m_valid = 0; m_ctrl = '0; m_d1 = '0; m_d2 = '0;
            m_imm = '0; m_ins = '0; m_pc = '0;
        end else if (!stall_in) begin
            m_valid = id_valid_in;
            m_ctrl  = id_valid_in ? id_ctrl_in : 10'h000;
            m_d1 = id_read_data1_in; m_d2 = id_read_data2_in; m_imm = id_imm_in;
            m_ins = id_instruction_in; m_pc = id_pc_in;
        end
        #1;
        checkOutput(tag);
    endtask

    localparam logic [31:0] LW8      = {6'h23, 5'd0, 5'd8, 16'h0004};
    localparam logic [31:0] LW0      = {6'h23, 5'd0, 5'd0, 16'h0004};
    localparam logic [31:0] LW8_SELF = {6'h23, 5'd8, 5'd8, 16'h0000};
    localparam logic [31:0] ADD98_10 = {6'h00, 5'd8, 5'd10, 5'd9, 11'h020};
    localparam logic [31:0] ADD_RS0  = {6'h00, 5'd0, 5'd10, 5'd9, 11'h020};
    localparam logic [31:0] ADDI8    = {6'h08, 5'd3, 5'd8, 16'h0010};
    localparam logic [9:0]  C_LW     = 10'h039;
    localparam logic [9:0]  C_ADD    = 10'h0A2;
    localparam logic [9:0]  C_ADDI   = 10'h021;

    initial begin
        int exp_sat[5];
        logic [4:0] regs[4];
        exp_sat = '{1, 2, 3, 3, 3};
        regs    = '{5'd0, 5'd8, 5'd9, 5'd8};

        reset = 1'b1;
        applyStimulus(0, 0, '0, '0, '0, 0, 0);
        modelClear();
        #12 reset = 1'b0;
        #1 checkOutput("reset");

        // Fill EX with all-ones, then reset between edges
        @(posedge clk); #1;
        applyStimulus(1, 1, 10'h3FF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        id_read_data1_in = '1; id_read_data2_in = '1; id_imm_in = '1;
        stepClock("ones");
        #2 reset = 1'b1;
        #1 modelClear();
        checkOutput("async_reset");
        #1 reset = 1'b0;
        applyStimulus(1, 0, C_ADDI, 32'h0, 32'h0000_0008, 0, 0);
        stepClock("first_load");
        chk("first_pc", ex_pc_out, 32'h0000_0008);

        // Load-use: lw $8 then add $9,$8,$10
        applyStimulus(1, 0, C_LW, LW8, 32'h10, 0, 0);
        stepClock("lw8");
        applyStimulus(1, 1, C_ADD, ADD98_10, 32'h14, 0, 0);
        #1 chk("lu_hazard", 32'(hazard_stall_out), 32'd1);
        stepClock("lu_bubble");
        chk("lu_count", 32'(bubble_count_out), 32'd1);
        stepClock("lu_release");
        chk("lu_clear", 32'(hazard_stall_out), 32'd0);

        // $0 target and rt not used as a source
        applyStimulus(1, 0, C_LW, LW0, 32'h18, 0, 0);
        stepClock("lw0");
        applyStimulus(1, 1, C_ADD, ADD_RS0, 32'h1C, 0, 0);
        #1 chk("zero_reg", 32'(hazard_stall_out), 32'd0);
        applyStimulus(1, 0, C_LW, LW8, 32'h20, 0, 0);
        stepClock("lw8b");
        applyStimulus(1, 0, C_ADDI, ADDI8, 32'h24, 0, 0);
        #1 chk("rt_unused", 32'(hazard_stall_out), 32'd0);

        // Hold for three cycles with a pending hazard and changing data
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, C_ADD, ADD98_10, 32'h100 + 32'(i), 1, 0);
            stepClock("stall");
        end
        chk("stall_pc", ex_pc_out, 32'h20);

        // Flush beats stall and load-use
        applyStimulus(1, 1, C_ADD, ADD98_10, 32'h200, 1, 1);
        #1 chk("flush_hazard", 32'(hazard_stall_out), 32'd0);
        stepClock("flush");

        // Saturation in the 2-bit counter
        reset = 1'b1; #1 modelClear(); reset = 1'b0;
        applyStimulus(1, 0, C_LW, LW8_SELF, 32'h300, 0, 0);
        stepClock("sat_fill");
        for (int k = 0; k < 5; k++) begin
            stepClock("sat_bubble");
            chk("sat_seq", 32'(s_count), 32'(exp_sat[k]));
            stepClock("sat_load");
        end

        // Random traffic over a small register set so dependencies are frequent
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ins;
            logic [9:0]  ctrl;
            ins  = $urandom;
            ins[25:21] = regs[$urandom_range(0, 3)];
            ins[20:16] = regs[$urandom_range(0, 3)];
            ctrl = 10'($urandom);
            applyStimulus($urandom_range(0, 9) != 0, 1'($urandom), ctrl, ins, $urandom,
                          $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0);
            if ($urandom_range(0, 99) == 0) begin
                #2 reset = 1'b1;
                #1 modelClear();
                checkOutput("rand_reset");
                reset = 1'b0;
            end
            stepClock("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
